// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier design-space-exploration candidates.
// Default sizing, product-width helper and product vector type.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 2;
  localparam int PROD_W_DEFAULT = 2 * WIDTH_DEFAULT;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  typedef logic [PROD_W_DEFAULT-1:0] prod_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell for the partial-product reduction array.
// Used as a half adder by tying cin to 0.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign s     = w_axb ^ cin;
  assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/multiplier_2x2.sv
// Unsigned array multiplier: partial products reduced by ripple-carry rows.
// Operand pair accepted on in_valid, product registered once.
module multiplier_2x2
  import mult_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int PW    = prod_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [PW-1:0]    P
);

  logic [PW-1:0] w_prod;
  logic [PW-1:0] r_p;
  logic          r_vld;

  // Row i holds the running sum shifted so bit 0 is product bit i.
  // Each row adds the next partial product to the upper bits of
  // the previous row; the final row's upper bits are the top half.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [WIDTH-1:0] w_pp;
    logic [WIDTH:0]   w_s;

    assign w_pp = A & {WIDTH{B[i]}};

    if (i == 0) begin : g_first
      assign w_s = {1'b0, w_pp};
    end else begin : g_add
      for (genvar j = 0; j < WIDTH; j++) begin : g_col
        logic w_cin;
        logic w_co;

        if (j == 0) begin : g_ha
          assign w_cin = 1'b0;
        end else begin : g_fa
          assign w_cin = g_col[j-1].w_co;
        end

        full_adder u_fa (
          .a    (g_row[i-1].w_s[j+1]),
          .b    (w_pp[j]),
          .cin  (w_cin),
          .s    (w_s[j]),
          .cout (w_co)
        );
      end
      assign w_s[WIDTH] = g_col[WIDTH-1].w_co;
    end

    assign w_prod[i] = w_s[0];
  end

  assign w_prod[PW-1:WIDTH] = g_row[WIDTH-1].w_s[WIDTH:1];

  // Capture the product on valid input; hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_p <= w_prod;
      end
    end
  end

  assign P         = r_p;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_multiplier_2x2.sv
// Self-checking bench for multiplier_2x2 at WIDTH=2 and WIDTH=8.
// Arithmetic reference model plus literal expectations.
module tb_multiplier_2x2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v2 = 1'b0;
  logic [1:0]  a2 = '0;
  logic [1:0]  b2 = '0;
  logic        ov2;
  logic [3:0]  p2;
  logic        v8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ov8;
  logic [15:0] p8;

  int checks = 0;
  int failures = 0;
  bit en_cmp = 1'b0;

  logic [3:0]  m2_p = '0;
  logic        m2_v = 1'b0;
  logic [15:0] m8_p = '0;
  logic        m8_v = 1'b0;

  multiplier_2x2 #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2),
    .A(a2), .B(b2), .out_valid(ov2), .P(p2)
  );

  multiplier_2x2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .A(a8), .B(b8), .out_valid(ov8), .P(p8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: result of the last accepted pair, valid one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_p = '0; m2_v = 1'b0;
      m8_p = '0; m8_v = 1'b0;
    end else begin
      m2_v = v2;
      if (v2) m2_p = 4'(int'(a2) * int'(b2));
      m8_v = v8;
      if (v8) m8_p = 16'(int'(a8) * int'(b8));
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (en_cmp) begin
      chk("w2_valid", 32'(ov2), 32'(m2_v));
      chk("w2_prod", 32'(p2), 32'(m2_p));
      chk("w8_valid", 32'(ov8), 32'(m8_v));
      chk("w8_prod", 32'(p8), 32'(m8_p));
    end
  end

  task automatic drv2(input logic v, input logic [1:0] a,
                      input logic [1:0] b);
    @(negedge clk); #1;
    v2 = v; a2 = a; b2 = b;
  endtask

  task automatic drv8(input logic v, input logic [7:0] a,
                      input logic [7:0] b);
    @(negedge clk); #1;
    v8 = v; a8 = a; b8 = b;
  endtask

  task automatic after_edge;
    @(posedge clk); #1;
  endtask

  int d_a[7] = '{1, 2, 1, 3, 2, 3, 3};
  int d_b[7] = '{3, 1, 2, 1, 2, 2, 3};
  int d_p[7] = '{3, 2, 2, 3, 4, 6, 9};

  initial begin
    en_cmp = 1'b1;
    repeat (3) after_edge();
    chk("rst_p2", 32'(p2), 0);
    chk("rst_v2", 32'(ov2), 0);
    chk("rst_p8", 32'(p8), 0);

    @(negedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      drv2(1'b1, 2'(d_a[k]), 2'(d_b[k]));
      after_edge();
      chk("dir_p", 32'(p2), 32'(d_p[k]));
      chk("dir_v", 32'(ov2), 1);
    end

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        drv2(1'b1, 2'(a), 2'(b));
      end
    end
    repeat (3) begin
      drv2(1'b1, 2'd2, 2'd1);
      after_edge();
      chk("rep_21", 32'(p2), 2);
    end

    drv2(1'b1, 2'd3, 2'd3);
    after_edge();
    chk("hold_pre", 32'(p2), 9);
    drv2(1'b0, 2'd1, 2'd1);
    after_edge();
    chk("hold_v", 32'(ov2), 0);
    chk("hold_p", 32'(p2), 9);

    drv2(1'b1, 2'd3, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_p", 32'(p2), 0);
    chk("arst_v", 32'(ov2), 0);
    after_edge();
    chk("arst_hold", 32'(p2), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    v2 = 1'b1; a2 = 2'd2; b2 = 2'd2;
    after_edge();
    chk("post_rst_p", 32'(p2), 4);
    chk("post_rst_v", 32'(ov2), 1);

    drv2(1'b0, 2'd0, 2'd0);
    drv8(1'b1, 8'd255, 8'd255);
    after_edge();
    chk("w8_max", 32'(p8), 65025);
    drv8(1'b1, 8'd128, 8'd2);
    after_edge();
    chk("w8_128x2", 32'(p8), 256);
    drv8(1'b1, 8'd0, 8'd200);
    after_edge();
    chk("w8_zero", 32'(p8), 0);

    for (int n = 0; n < 1000; n++) begin
      @(negedge clk); #1;
      v8 = ($urandom_range(3) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v2 = ($urandom_range(3) != 0);
      a2 = 2'($urandom);
      b2 = 2'($urandom);
    end
    @(negedge clk); #1;
    v2 = 1'b0; v8 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    en_cmp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
